seq_chunk_adder: RTL and testbench
==================================

// Module: seq_chunk_adder
// PURPOSE
//  Parametrised multi-cycle ripple adder, successor to the single-bit full_addr cell.
//  Adds two WIDTH-bit operands plus carry-in CHUNK bits per clock, holding carry in a register.
//  Valid/ready handshake on both sides. Sits between operand producers and result consumers.
// PARAMETERS
//  WIDTH  32  operand/sum width in bits; must be a multiple of CHUNK
//  CHUNK  8   bits added per cycle; NCHUNK = WIDTH/CHUNK cycles per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      a/b/c_in valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      carry into bit 0
//  out_valid  out  1      sum/c_out valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  registered result
//  c_out      out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow; present only with SEQ_ADDER_OVF_EN
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, sum=0, c_out=0, ovf=0, chunk index=0, carry reg=0.
//   in_ready is decoded from state, so it is 1 during reset and immediately after it.
//  FSM, three states:
//   IDLE: in_ready=1. On in_valid&in_ready, capture a, b, c_in; carry<=c_in; idx<=0; go to BUSY.
//   BUSY: each cycle sum[idx*CHUNK +: CHUNK] <= a_chunk + b_chunk + carry; carry <= chunk carry-out.
//    When idx==NCHUNK-1: c_out <= chunk carry-out; go to DONE. Otherwise idx++.
//   DONE: out_valid=1; sum, c_out and ovf are held stable. On out_ready, go to IDLE.
//  Latency: the accept edge is E. out_valid rises after edge E+NCHUNK.
//   With NCHUNK=1, there is exactly one BUSY cycle.
//  Throughput: one operation per NCHUNK+2 cycles at best. No accept while in DONE.
//  Operand pins are sampled only at accept; changes during BUSY/DONE are ignored.
//  in_valid outside IDLE is ignored; no queuing.
//  The upper sum chunks may hold the previous result until overwritten.
//   Consumers read sum only while out_valid=1.
//  Arithmetic: unsigned modulo 2^WIDTH. The carry out of bit WIDTH-1 is reported only on c_out.
//  Reset mid-operation (BUSY or DONE): the transaction is discarded and all reset values apply.
//   No result is produced.
//  out_ready held high in DONE: handshake completes on the first DONE cycle.
// CONFIGURATION
//  SEQ_ADDER_OVF_EN defined: ovf port exists.
//   ovf <= carry_into_msb ^ carry_out_of_msb, registered on the final BUSY cycle.
//   ovf is held in DONE and reset to 0.
//  SEQ_ADDER_OVF_EN undefined: no ovf port, no logic; all other behaviour identical.
// STRUCTURE
//  Package adder_pkg: state typedef {IDLE, BUSY, DONE}; function clog2 for idx width.
//   The idx register is max(1, clog2(NCHUNK)) bits wide.
//  Sub-module chunk_adder: combinational CHUNK-bit ripple adder.
//   Ports (a, b, c_in, sum, c_out, c_msb); it is a generate chain of full_addr cells.
//   c_msb is the carry into its top bit, used for ovf.
//  Top level holds the FSM, operand/sum/carry registers and the chunk mux/demux.
// TESTING (WIDTH=32, CHUNK=8 unless noted)
//  1. a=0x000000FF, b=0x1, c_in=0 -> sum=0x00000100, c_out=0; out_valid 4 edges after accept.
//  2. a=0xFFFFFFFF, b=0, c_in=1 -> sum=0x00000000, c_out=1 (carry ripples through all 4 chunks).
//  3. Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands.
//   -> sum/c_out/out_valid stable, in_ready=0, new operands ignored.
//  4. Assert rst on the 2nd BUSY cycle. -> out_valid=0, sum=0, in_ready=1 immediately.
//   The next transaction a=3, b=4 yields sum=7.
//  5. SEQ_ADDER_OVF_EN: a=0x7FFFFFFF, b=1 -> sum=0x80000000, ovf=1, c_out=0.
//   a=0x80000000, b=0x80000000 -> sum=0, c_out=1, ovf=1. a=5, b=6 -> ovf=0.
//  6. WIDTH=1, CHUNK=1 instance: all 8 (a, b, c_in) rows match the full-adder truth table.
//   Latency is 1 edge after accept.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the sequential chunked adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from a chain of full_addr cells.
module chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_addr u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (c[i]),
            .sum   (sum[i]),
            .c_out (c[i+1])
        );
    end

    assign c_out = c[CHUNK];
    // Carry into the top bit; xor with c_out gives signed overflow.
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_addr.sv
// Single-bit full adder cell, the building block of chunk_adder.
module full_addr (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: adds CHUNK bits per clock with a registered carry.
// Define SEQ_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IW     = (clog2(NCHUNK) > 1) ? clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             co_chunk;
`ifdef SEQ_ADDER_OVF_EN
    logic             msb_chunk;
`else
    logic             msb_chunk_unused;
`endif

    assign in_ready = (state == IDLE);

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (idx == IW'(k)) begin
                a_chunk = a_r[k*CHUNK +: CHUNK];
                b_chunk = b_r[k*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (a_chunk),
        .b     (b_chunk),
        .c_in  (carry),
        .sum   (s_chunk),
        .c_out (co_chunk),
`ifdef SEQ_ADDER_OVF_EN
        .c_msb (msb_chunk)
`else
        .c_msb (msb_chunk_unused)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            carry     <= 1'b0;
            idx       <= '0;
            a_r       <= '0;
            b_r       <= '0;
`ifdef SEQ_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= c_in;
                        idx   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Only the active chunk is written; the rest keep prior contents.
                    for (int unsigned k = 0; k < NCHUNK; k++) begin
                        if (idx == IW'(k)) begin
                            sum[k*CHUNK +: CHUNK] <= s_chunk;
                        end
                    end
                    carry <= co_chunk;
                    if (idx == LAST) begin
                        c_out     <= co_chunk;
`ifdef SEQ_ADDER_OVF_EN
                        ovf       <= msb_chunk ^ co_chunk;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Randomised and directed bench for seq_chunk_adder (32/8 and 1/1 instances).
// Define SEQ_ADDER_OVF_EN to also check ovf.
`timescale 1ns/1ps
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        c_out;

    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [0:0]  a1 = '0;
    logic [0:0]  b1 = '0;
    logic        c_in1 = 1'b0;
    logic        out_valid1;
    logic        out_ready1 = 1'b0;
    logic [0:0]  sum1;
    logic        c_out1;

`ifdef SEQ_ADDER_OVF_EN
    logic        ovf;
    logic        ovf1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef SEQ_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    seq_chunk_adder #(.WIDTH(1), .CHUNK(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .c_in      (c_in1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .c_out     (c_out1)
`ifdef SEQ_ADDER_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    // Reference: plain integer arithmetic on the full operands.
    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {32'd0, c};
    endfunction

    function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y, input logic c);
        longint s;
        s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Accept one operation, scramble the pins afterwards, wait for out_valid.
    task automatic start_wait(input logic [31:0] ai, input logic [31:0] bi, input logic ci, output int lat);
        @(negedge clk);
        a = ai; b = bi; c_in = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; c_in = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (sum !== 32'd0) begin errors++; $display("FAIL rst_sum got %h exp 0", sum); end
        checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL rst_c_out got %b exp 0", c_out); end
        checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || sum1 !== 1'b0) begin
            errors++; $display("FAIL rst_w1 got rdy=%b vld=%b sum=%b exp 1 0 0", in_ready1, out_valid1, sum1);
        end
`ifdef SEQ_ADDER_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_directed();
        int lat;
        start_wait(32'h000000FF, 32'h1, 1'b0, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL d1_latency got %0d exp 4", lat); end
        checks++; if (sum !== 32'h00000100) begin errors++; $display("FAIL d1_sum got %h exp 00000100", sum); end
        checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL d1_c_out got %b exp 0", c_out); end
        release_out();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL d1_handshake got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
        end
        start_wait(32'hFFFFFFFF, 32'h0, 1'b1, lat);
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL d2_sum got %h exp 0", sum); end
        checks++; if (c_out !== 1'b1) begin errors++; $display("FAIL d2_c_out got %b exp 1", c_out); end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [32:0] e;
        e = ref_add(32'h12345678, 32'hF0F0F0F0, 1'b1);
        start_wait(32'h12345678, 32'hF0F0F0F0, 1'b1, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = $urandom; b = $urandom; c_in = 1'($urandom);
            #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_flags cyc %0d got vld=%b rdy=%b exp 1 0", i, out_valid, in_ready);
            end
            checks++; if ({c_out, sum} !== e) begin
                errors++; $display("FAIL bp_result cyc %0d got %b_%h exp %b_%h", i, c_out, sum, e[32], e[31:0]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        @(negedge clk);
        a = 32'hAAAA5555; b = 32'h11112222; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_out_valid got %b exp 0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL mr_sum got %h exp 0", sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready got %b exp 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        start_wait(32'd3, 32'd4, 1'b0, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL mr_next_latency got %0d exp 4", lat); end
        checks++; if (sum !== 32'd7 || c_out !== 1'b0) begin
            errors++; $display("FAIL mr_next_sum got %h c=%b exp 00000007 c=0", sum, c_out);
        end
        release_out();
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] x, y;
        logic c;
        logic [32:0] e;
        for (int n = 0; n < 40; n++) begin
            x = $urandom; y = $urandom; c = 1'($urandom);
            if (n % 8 == 0) y = ~x;
            e = ref_add(x, y, c);
            start_wait(x, y, c, lat);
            checks++; if (lat != 4) begin errors++; $display("FAIL rnd_latency n=%0d got %0d exp 4", n, lat); end
            checks++; if ({c_out, sum} !== e) begin
                errors++; $display("FAIL rnd_sum n=%0d %h+%h+%b got %b_%h exp %b_%h", n, x, y, c, c_out, sum, e[32], e[31:0]);
            end
`ifdef SEQ_ADDER_OVF_EN
            checks++; if (ovf !== ref_ovf(x, y, c)) begin
                errors++; $display("FAIL rnd_ovf n=%0d got %b exp %b", n, ovf, ref_ovf(x, y, c));
            end
`endif
            release_out();
        end
    endtask

`ifdef SEQ_ADDER_OVF_EN
    task automatic test_ovf();
        int lat;
        start_wait(32'h7FFFFFFF, 32'h1, 1'b0, lat);
        checks++; if (sum !== 32'h80000000 || ovf !== 1'b1 || c_out !== 1'b0) begin
            errors++; $display("FAIL ovf_pos got %h ovf=%b c=%b exp 80000000 1 0", sum, ovf, c_out);
        end
        release_out();
        start_wait(32'h80000000, 32'h80000000, 1'b0, lat);
        checks++; if (sum !== 32'h0 || ovf !== 1'b1 || c_out !== 1'b1) begin
            errors++; $display("FAIL ovf_neg got %h ovf=%b c=%b exp 00000000 1 1", sum, ovf, c_out);
        end
        release_out();
        start_wait(32'd5, 32'd6, 1'b0, lat);
        checks++; if (sum !== 32'd11 || ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_none got %h ovf=%b exp 0000000b 0", sum, ovf);
        end
        release_out();
    endtask
`endif

    task automatic test_width1();
        int lat;
        int total;
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            a1 = 1'(r >> 2); b1 = 1'(r >> 1); c_in1 = 1'(r); in_valid1 = 1'b1;
            total = (r >> 2) % 2 + (r >> 1) % 2 + r % 2;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            lat = 0;
            while (out_valid1 !== 1'b1 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++; if (lat != 1) begin errors++; $display("FAIL w1_latency row %0d got %0d exp 1", r, lat); end
            checks++; if ({c_out1, sum1} !== 2'(total)) begin
                errors++; $display("FAIL w1_row %0d got %b%b exp %b", r, c_out1, sum1, 2'(total));
            end
`ifdef SEQ_ADDER_OVF_EN
            // 1-bit signed range is [-1, 0].
            checks++; if (ovf1 !== ((-((r >> 2) % 2) - ((r >> 1) % 2) + r % 2) > 0 ||
                                    (-((r >> 2) % 2) - ((r >> 1) % 2) + r % 2) < -1)) begin
                errors++; $display("FAIL w1_ovf row %0d got %b", r, ovf1);
            end
`endif
            @(negedge clk);
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_mid_reset();
        test_random();
`ifdef SEQ_ADDER_OVF_EN
        test_ovf();
`endif
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
